cpucr_dma: RTL and testbench
============================

Name: cpucr_dma

Overview:
- Single-channel memory-to-memory DMA engine; sits beside the CPUCR core on the shared memory bus.
- Sources the core's SDMA bus request and consumes its BD bus-granted output.
- While granted, drives Direccion/data/LE into memoria to copy a block of bytes.
- Signals completion to the core via the INT line (active-low, matching how the system idles INT=1).

Parameters:
- ADDR_W, 16, memory address width (matches Direccion)
- DATA_W, 8, memory data width (matches data)
- LEN_W, 16, byte-count width
- BURST, 16, max bytes per bus tenure (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- RPS  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; launches a transfer with src/dst/len
- src  in  ADDR_W  source start address, sampled on start
- dst  in  ADDR_W  destination start address, sampled on start
- len  in  LEN_W  byte count, sampled on start
- SDMA  out  1  bus request to CPUCR, active-low
- BD  in  1  bus granted by CPUCR, active-high
- Direccion  out  ADDR_W  memory address; high-Z when not granted
- data  inout  DATA_W  memory data; driven only in WR state
- LE  out  1  memory write strobe, active-high; high-Z when not granted
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion
- INT  out  1  completion interrupt, active-low; held low until next start

Behaviour:
- Reset values: SDMA=1, busy=0, done=0, INT=1. Direccion, LE and data are high-Z. FSM is in IDLE; counters are 0.
- FSM states: IDLE, REQ, RD, WR, NEXT, REL.
- IDLE:
  - start with len≠0 → latch src/dst/len, busy=1, INT=1, go to REQ.
  - start with len=0 → done pulse, INT=0, no bus request, stay in IDLE.
- REQ: SDMA=0. Wait for BD=1 → RD. No timeout.
- RD:
  - Drive Direccion=src_cnt, LE=0.
  - Memory is combinational, so data is latched into the holding register at the clock edge ending RD.
  - If BD=0 when sampled in RD: discard the latched data, no address advance, return to REQ.
- WR: drive Direccion=dst_cnt, data=hold, LE=1 for exactly one cycle.
- NEXT:
  - src_cnt+1 and dst_cnt+1, each wrapping modulo 2^ADDR_W (0xFFFF→0x0000).
  - len_cnt−1.
  - len_cnt reaches 0 → REL; otherwise → RD.
  - Throughput: 3 cycles per byte.
- REL:
  - SDMA=1, bus outputs tri-stated.
  - Wait for BD=0, then → IDLE with done=1 for one cycle, busy=0, INT=0.
- start while busy is ignored.
- RPS=1 mid-transfer aborts immediately to reset values. No done pulse; the partial copy is left as is.
- Bus outputs are never driven unless the state is RD/WR/NEXT and BD=1. NEXT keeps driving Direccion=dst_cnt with LE=0.

Optional Feature:
- Macro: CPUCR_DMA_BURST_LIMIT_EN.
- Defined:
  - A per-tenure byte counter forces NEXT→REL after BURST bytes when len_cnt≠0.
  - After BD=0, the FSM re-enters REQ instead of IDLE, with no done pulse.
  - The CPU gets at least one cycle of bus between tenures.
- Undefined: the whole block is copied in one tenure. The BURST parameter is unused.

Decomposition:
- Package cpucr_dma_pkg holds:
  - the state enum (IDLE, REQ, RD, WR, NEXT, REL)
  - polarity constants SDMA_ACT=0, INT_ACT=0, LE_WR=1
  - default widths
- One natural sub-module, cpucr_dma_counter: a loadable up/down counter with wrap and zero flag, used for src_cnt, dst_cnt and len_cnt.

Test Plan:
- Reset: RPS=1 for 2 cycles → SDMA=1, INT=1, busy=0, bus high-Z. Memory is unchanged.
- Basic copy:
  - Stimulus: mem[0x0010..0x0013]=A1,B2,C3,D4; start src=0x0010 dst=0x0080 len=4; BD=1 two cycles after SDMA falls.
  - Required: mem[0x0080..0x0083]=A1,B2,C3,D4.
  - Required: done pulse exactly 12 cycles after the grant edge plus REL; INT low.
- len=0: start → done next cycle, SDMA never falls, INT=0.
- Wrap: src=0xFFFE dst=0x0100 len=3 → bytes read from 0xFFFE, 0xFFFF, 0x0000.
- Grant loss: BD dropped during the 2nd RD → SDMA stays 0, RD is re-executed after re-grant, final copy is correct, no duplicate or skipped byte.
- With CPUCR_DMA_BURST_LIMIT_EN and BURST=2, len=5 → SDMA rises 2 times mid-transfer, then once at the end; single done pulse; data correct.

Source files
------------

// File: rtl/cpucr_dma_pkg.sv
// Shared types and constants for the CPUCR single-channel memory-to-memory DMA.
// Optional feature macro used elsewhere: CPUCR_DMA_BURST_LIMIT_EN.
package cpucr_dma_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;
  localparam int BURST_DEF  = 16;

  // Line polarities as seen by the CPUCR core and memoria
  localparam logic SDMA_ACT = 1'b0;
  localparam logic INT_ACT  = 1'b0;
  localparam logic LE_WR    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    NEXT,
    REL
  } state_t;

endpackage

// File: rtl/cpucr_dma_if.sv
// Control and bus-arbitration handshake between the DMA engine (master) and the
// CPU side (slave): transfer launch, SDMA/BD request-grant, status and INT.
interface cpucr_dma_if
  import cpucr_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              SDMA;
  logic              BD;
  logic              busy;
  logic              done;
  logic              INT;

  modport master (
    input  start, src, dst, len, BD,
    output SDMA, busy, done, INT
  );

  modport slave (
    output start, src, dst, len, BD,
    input  SDMA, busy, done, INT
  );
endinterface

// File: rtl/cpucr_dma_counter.sv
// Loadable up/down counter with natural modulo-2^W wrap and a zero flag.
module cpucr_dma_counter
  import cpucr_dma_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (inc && !dec) begin
      cnt_reg <= cnt_reg + W'(1);
    end else if (dec && !inc) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/cpucr_dma.sv
// Single-channel memory-to-memory DMA beside the CPUCR core: requests the bus,
// copies len bytes src->dst at 3 cycles/byte, then raises done and pulls INT low.
// Optional macro CPUCR_DMA_BURST_LIMIT_EN caps each bus tenure at BURST bytes.
module cpucr_dma
  import cpucr_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int BURST  = BURST_DEF
) (
  input  logic              clk,
  input  logic              RPS,
  cpucr_dma_if.master       ctl,
  output wire [ADDR_W-1:0]  Direccion,
  inout  wire [DATA_W-1:0]  data,
  output wire               LE
);
  state_t                      state_reg;
  logic                        sdma_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic                        int_reg;
  logic                        le_reg;
  logic [DATA_W-1:0]           hold_reg;

  logic [1:0][ADDR_W-1:0]      addr_cnt;
  logic [1:0]                  addr_zero;
  logic [1:0][ADDR_W-1:0]      addr_load;
  logic [LEN_W-1:0]            len_cnt;
  logic                        len_zero;
  logic                        xfer_load;
  logic                        step;
  logic                        tenure_full;
  logic                        bus_en;
  logic                        unused_ok;

  assign xfer_load    = (state_reg == IDLE) && ctl.start && (ctl.len != '0);
  assign step         = (state_reg == NEXT);
  assign addr_load[0] = ctl.src;
  assign addr_load[1] = ctl.dst;

  // Index 0 walks the source, index 1 the destination.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_addr
      cpucr_dma_counter #(.W(ADDR_W)) u_addr (
        .clk      (clk),
        .srst     (RPS),
        .load     (xfer_load),
        .load_val (addr_load[gi]),
        .inc      (step),
        .dec      (1'b0),
        .cnt      (addr_cnt[gi]),
        .zero     (addr_zero[gi])
      );
    end
  endgenerate

  cpucr_dma_counter #(.W(LEN_W)) u_len (
    .clk      (clk),
    .srst     (RPS),
    .load     (xfer_load),
    .load_val (ctl.len),
    .inc      (1'b0),
    .dec      (step),
    .cnt      (len_cnt),
    .zero     (len_zero)
  );

`ifdef CPUCR_DMA_BURST_LIMIT_EN
  localparam int BW = $clog2(BURST + 1);
  logic [BW-1:0] tenure_cnt_reg;

  // Bytes completed in the current tenure; every fresh request starts a new one.
  always_ff @(posedge clk) begin
    if (RPS || state_reg == REQ) begin
      tenure_cnt_reg <= '0;
    end else if (step) begin
      tenure_cnt_reg <= tenure_cnt_reg + BW'(1);
    end
  end

  assign tenure_full = (tenure_cnt_reg == BW'(BURST - 1));
`else
  assign tenure_full = 1'b0;
`endif

  assign unused_ok = ^{addr_zero, (BURST == 0)};

  always_ff @(posedge clk) begin
    if (RPS) begin
      state_reg <= IDLE;
      sdma_reg  <= ~SDMA_ACT;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      int_reg   <= ~INT_ACT;
      le_reg    <= ~LE_WR;
      hold_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ctl.start) begin
            if (ctl.len != '0) begin
              state_reg <= REQ;
              sdma_reg  <= SDMA_ACT;
              busy_reg  <= 1'b1;
              int_reg   <= ~INT_ACT;
            end else begin
              done_reg  <= 1'b1;
              int_reg   <= INT_ACT;
            end
          end
        end
        REQ: begin
          if (ctl.BD) state_reg <= RD;
        end
        RD: begin
          // A grant lost mid-read leaves the counters alone so the byte is redone.
          if (ctl.BD) begin
            hold_reg  <= data;
            le_reg    <= LE_WR;
            state_reg <= WR;
          end else begin
            state_reg <= REQ;
          end
        end
        WR: begin
          le_reg    <= ~LE_WR;
          state_reg <= NEXT;
        end
        NEXT: begin
          if (len_cnt == LEN_W'(1) || tenure_full) begin
            state_reg <= REL;
            sdma_reg  <= ~SDMA_ACT;
          end else begin
            state_reg <= RD;
          end
        end
        REL: begin
          if (!ctl.BD) begin
            if (len_zero) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              int_reg   <= INT_ACT;
            end else begin
              state_reg <= REQ;
              sdma_reg  <= SDMA_ACT;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctl.SDMA = sdma_reg;
  assign ctl.busy = busy_reg;
  assign ctl.done = done_reg;
  assign ctl.INT  = int_reg;

  // The grant gates the drivers directly so the bus is released the cycle BD falls.
  assign bus_en    = ctl.BD && (state_reg == RD || state_reg == WR || state_reg == NEXT);
  assign Direccion = bus_en ? ((state_reg == RD) ? addr_cnt[0] : addr_cnt[1]) : {ADDR_W{1'bz}};
  assign LE        = bus_en ? le_reg : 1'bz;
  assign data      = (bus_en && state_reg == WR) ? hold_reg : {DATA_W{1'bz}};
endmodule

// File: tb/tb_cpucr_dma.sv
// Directed plus randomized bench for cpucr_dma: a byte-wise copy model predicts
// every memory write and the final memory image; a CPU model grants/drops BD.
module tb_cpucr_dma;
  localparam int TB_BURST = 2;

  logic        clk;
  logic        RPS;
  wire  [15:0] Direccion;
  wire  [7:0]  data;
  wire         LE;

  int checks   = 0;
  int failures = 0;
  int xfer_no  = 0;

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  scratch [65536];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_v[$];

  cpucr_dma_if #(.ADDR_W(16), .LEN_W(16)) ctl ();

  cpucr_dma #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .BURST(TB_BURST)) dut (
    .clk       (clk),
    .RPS       (RPS),
    .ctl       (ctl),
    .Direccion (Direccion),
    .data      (data),
    .LE        (LE)
  );

  // Combinational memory: drives data unless the DMA is strobing a write.
  assign data = (LE !== 1'b1) ? mem[Direccion] : 8'bz;
  always @(posedge clk) if (LE === 1'b1) mem[Direccion] <= data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk(tag, mism, 0);
  endtask

  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                          input int gdelay, input int drop_k, input int abort_at,
                          input bit extra_start);
    int c = 0, wait_cnt = 0, grant_neg = -100, done_cyc = -1, falls = 0, exp_falls;
    int drop_left = drop_k;
    bit got_done = 0, aborted = 0;
    logic prev_sdma = 1'b1;
    logic [15:0] as, ad;

    // Reference: copy byte by byte in order, so overlapping ranges behave as the engine does.
    exp_a.delete(); exp_v.delete();
    for (int i = 0; i < 65536; i++) scratch[i] = ref_mem[i];
    for (int i = 0; i < int'(n); i++) begin
      as = s + 16'(i);
      ad = d + 16'(i);
      scratch[ad] = scratch[as];
      exp_a.push_back(ad);
      exp_v.push_back(scratch[as]);
    end

    ctl.start = 1'b1; ctl.src = s; ctl.dst = d; ctl.len = n;
    while (!got_done && !aborted && c < 600) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        ctl.start = 1'b0;
        if (n != 0) begin
          chk("busy_on", ctl.busy, 1);
          chk("int_cleared", ctl.INT, 1);
        end
      end
      if (extra_start && c == 5) begin
        ctl.start = 1'b1; ctl.src = 16'hAAAA; ctl.dst = 16'hBBBB; ctl.len = 16'd1;
      end
      if (extra_start && c == 6) ctl.start = 1'b0;
      if (ctl.SDMA === 1'b0 && prev_sdma === 1'b1) falls++;
      prev_sdma = ctl.SDMA;
      if (LE === 1'b1) begin
        if (exp_a.size() == 0) begin
          chk("extra_write_addr", Direccion, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", Direccion, exp_a[0]);
          chk("wr_data", data, exp_v[0]);
          ref_mem[exp_a[0]] = exp_v[0];
          void'(exp_a.pop_front());
          void'(exp_v.pop_front());
        end
      end
      if (ctl.done === 1'b1) begin
        got_done = 1;
        done_cyc = c;
      end
      if (abort_at > 0 && c == abort_at) begin
        RPS = 1'b1;
        aborted = 1;
      end else if (ctl.SDMA === 1'b1) begin
        ctl.BD = 1'b0; wait_cnt = 0;
      end else if (ctl.BD == 1'b0) begin
        if (wait_cnt >= gdelay) begin
          ctl.BD = 1'b1; grant_neg = c;
        end else begin
          wait_cnt++;
        end
      end else if (drop_left > 0 && c == grant_neg + 1 + 3 * drop_left) begin
        ctl.BD = 1'b0; drop_left = 0; wait_cnt = 0;
      end
    end

    if (aborted) begin
      chk("abort_no_done", got_done, 0);
      @(negedge clk);
      chk("abort_sdma", ctl.SDMA, 1);
      chk("abort_busy", ctl.busy, 0);
      chk("abort_int", ctl.INT, 1);
      chk("abort_done", ctl.done, 0);
      chk("abort_le_released", (LE === 1'b1), 0);
      RPS = 1'b0; ctl.BD = 1'b0;
      exp_a.delete(); exp_v.delete();
      @(negedge clk);
      chk_mem("abort_mem");
    end else begin
      chk("done_seen", got_done, 1);
`ifdef CPUCR_DMA_BURST_LIMIT_EN
      exp_falls = (int'(n) + TB_BURST - 1) / TB_BURST;
`else
      exp_falls = (n != 0) ? 1 : 0;
      if (n != 0 && drop_k == 0) chk("done_latency", done_cyc - grant_neg, 3 * int'(n) + 2);
`endif
      if (n == 0) chk("len0_done_cycle", done_cyc, 1);
      chk("sdma_falls", falls, exp_falls);
      chk("writes_left", exp_a.size(), 0);
      @(negedge clk);
      chk("done_width", ctl.done, 0);
      chk("int_low", ctl.INT, 0);
      chk("busy_off", ctl.busy, 0);
      chk("sdma_idle", ctl.SDMA, 1);
      chk_mem("mem_image");
    end
    xfer_no++;
    $display("xfer %0d src=%h dst=%h len=%0d gdelay=%0d drop=%0d abort=%0d falls=%0d done_at=%0d",
             xfer_no, s, d, n, gdelay, drop_k, abort_at, falls, done_cyc);
  endtask

  initial begin
    logic [15:0] rs, rd, rn;
    int rg, rdrop;

    RPS = 1'b1;
    ctl.start = 1'b0; ctl.src = '0; ctl.dst = '0; ctl.len = '0; ctl.BD = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_sdma", ctl.SDMA, 1);
    chk("rst_int", ctl.INT, 1);
    chk("rst_busy", ctl.busy, 0);
    chk("rst_done", ctl.done, 0);
    chk("rst_le_released", (LE === 1'b1), 0);
    RPS = 1'b0;
    @(negedge clk);
    chk("idle_sdma", ctl.SDMA, 1);
    chk_mem("rst_mem");

    // Basic copy of A1..D4, grant two cycles after the request.
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2; mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'hD4;
    for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = mem[i];
    run_xfer(16'h0010, 16'h0080, 16'd4, 1, 0, 0, 0);
    chk("basic_byte0", mem[16'h0080], 8'hA1);
    chk("basic_byte3", mem[16'h0083], 8'hD4);

    run_xfer(16'h0020, 16'h0090, 16'd0, 1, 0, 0, 0);

    // Address wrap at the top of memory.
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
    ref_mem[16'hFFFE] = 8'h11; ref_mem[16'hFFFF] = 8'h22; ref_mem[16'h0000] = 8'h33;
    run_xfer(16'hFFFE, 16'h0100, 16'd3, 0, 0, 0, 0);
    chk("wrap_byte2", mem[16'h0102], 8'h33);

    run_xfer(16'h0200, 16'h0300, 16'd4, 1, 1, 0, 0);
    run_xfer(16'h0400, 16'h0500, 16'd5, 0, 0, 0, 0);
    run_xfer(16'h0600, 16'h0700, 16'd6, 1, 0, 0, 1);
    run_xfer(16'h0800, 16'h0900, 16'd8, 0, 0, 10, 0);
    run_xfer(16'h0A00, 16'h0A02, 16'd5, 2, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = 16'($urandom_range(1, 20));
      rg = $urandom_range(0, 3);
      rdrop = (rn >= 2 && $urandom_range(0, 1) == 1) ? 1 : 0;
      run_xfer(rs, rd, rn, rg, rdrop, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
